// File: rtl/gnrl_skid_buf.sv
// Two-entry registered valid/ready stage: every output is driven from a flop.
// The main register feeds the consumer and the skid register absorbs one beat while the consumer stalls.
module gnrl_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [1:0]    o_lvl
);

    // State bits are {skid_vld, main_vld}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] main_dat;
    logic [DW-1:0] skid_dat;
    logic          main_ld;
    logic          main_sel_skid;
    logic          skid_ld;
    logic          in_xfer;
    logic          out_xfer;

    assign i_rdy    = ~state[1];
    assign o_vld    = state[0];
    assign o_dat    = main_dat;
    assign o_lvl    = {1'b0, state[0]} + {1'b0, state[1]};
    assign in_xfer  = i_vld & i_rdy;
    assign out_xfer = o_vld & o_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_ld   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_ld = 1'b1;
                end else if (in_xfer) begin
                    skid_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_nxt     = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Data registers move only under their load enables; main keeps its value once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dat <= '0;
        end else if (main_ld) begin
            main_dat <= main_sel_skid ? skid_dat : i_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_dat <= '0;
        end else if (skid_ld) begin
            skid_dat <= i_dat;
        end
    end

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
    a_i_vld_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(i_vld));
    a_o_rdy_known: assert property (@(posedge clk) disable iff (!rst_n)
        o_vld |-> !$isunknown(o_rdy));
`endif
`endif

endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Randomized and directed bench for gnrl_skid_buf with a queue-based scoreboard.
module tb_gnrl_skid_buf;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [1:0]    o_lvl;

    int checks = 0;
    int errors = 0;

    // Reference model: beats accepted but not yet delivered, in arrival order.
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_dat = '0;
    int            acc_cnt = 0;
    int            del_cnt = 0;
    int            disc_cnt = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    always #5 clk = ~clk;

    gnrl_skid_buf #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (i_vld),
        .i_rdy (i_rdy),
        .i_dat (i_dat),
        .o_vld (o_vld),
        .o_rdy (o_rdy),
        .o_dat (o_dat),
        .o_lvl (o_lvl)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge rst_n) begin
        disc_cnt  += q.size();
        q.delete();
        last_dat  = '0;
        prev_hold = 1'b0;
    end

    // Monitor: compares DUT against the model on the falling edge, then applies this cycle's transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_i_rdy", 64'(i_rdy), 64'd1);
            chk("rst_o_vld", 64'(o_vld), 64'd0);
            chk("rst_o_dat", 64'(o_dat), 64'd0);
            chk("rst_o_lvl", 64'(o_lvl), 64'd0);
        end else begin
            chk("lvl", 64'(o_lvl), 64'(q.size()));
            chk("o_vld", 64'(o_vld), 64'(q.size() != 0));
            chk("i_rdy", 64'(i_rdy), 64'(q.size() < 2));
            if (q.size() != 0) chk("o_dat_head", 64'(o_dat), 64'(q[0]));
            else               chk("o_dat_idle", 64'(o_dat), 64'(last_dat));
            if (prev_hold) begin
                chk("hold_vld", 64'(o_vld), 64'd1);
                chk("hold_dat", 64'(o_dat), 64'(prev_dat));
            end
            prev_hold = o_vld & ~o_rdy;
            prev_dat  = o_dat;
            if (o_vld && o_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_beat: got 0x%0h expected no beat at %0t", o_dat, $time);
                end else begin
                    last_dat = q.pop_front();
                    chk("out_beat", 64'(o_dat), 64'(last_dat));
                    del_cnt++;
                end
            end
            if (i_vld && i_rdy) begin
                q.push_back(i_dat);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int base;
        i_vld = 1'b0;
        o_rdy = 1'b0;
        i_dat = '0;

        // Reset held with random inputs
        repeat (5) begin
            step();
            i_vld = 1'($urandom_range(0, 1));
            o_rdy = 1'($urandom_range(0, 1));
            i_dat = $urandom;
        end
        step();
        rst_n = 1'b1;

        // First beat after reset
        i_vld = 1'b1;
        i_dat = 32'hA5A5_0001;
        o_rdy = 1'b0;
        step();
        i_vld = 1'b0;
        chk("t1_vld", 64'(o_vld), 64'd1);
        chk("t1_dat", 64'(o_dat), 64'hA5A5_0001);
        chk("t1_lvl", 64'(o_lvl), 64'd1);
        o_rdy = 1'b1;
        step();
        chk("t1_empty", 64'(o_lvl), 64'd0);

        // Streaming 1..64
        for (int k = 1; k <= 64; k++) begin
            i_vld = 1'b1;
            i_dat = DW'(k);
            step();
            chk("st_rdy", 64'(i_rdy), 64'd1);
            chk("st_lvl", 64'(o_lvl), 64'd1);
            chk("st_dat", 64'(o_dat), 64'(k));
        end
        i_vld = 1'b0;
        step();
        chk("st_end_lvl", 64'(o_lvl), 64'd0);

        // Stall and skid
        o_rdy = 1'b0;
        i_vld = 1'b1;
        i_dat = 32'h10;
        step();
        i_dat = 32'h11;
        step();
        i_dat = 32'h12;
        step();
        chk("sk_lvl", 64'(o_lvl), 64'd2);
        chk("sk_rdy", 64'(i_rdy), 64'd0);
        chk("sk_dat", 64'(o_dat), 64'h10);
        o_rdy = 1'b1;
        step();
        chk("sk_dat1", 64'(o_dat), 64'h11);
        step();
        chk("sk_dat2", 64'(o_dat), 64'h12);
        chk("sk_lvl2", 64'(o_lvl), 64'd1);

        // Fill to FULL then drain with no input
        o_rdy = 1'b0;
        i_dat = 32'h20;
        step();
        i_vld = 1'b0;
        chk("dr_lvl2", 64'(o_lvl), 64'd2);
        o_rdy = 1'b1;
        step();
        chk("dr_lvl1", 64'(o_lvl), 64'd1);
        chk("dr_dat1", 64'(o_dat), 64'h20);
        step();
        chk("dr_lvl0", 64'(o_lvl), 64'd0);
        chk("dr_vld0", 64'(o_vld), 64'd0);
        chk("dr_keep", 64'(o_dat), 64'h20);

        // Asynchronous reset pulse while FULL
        o_rdy = 1'b0;
        i_vld = 1'b1;
        i_dat = 32'h30;
        step();
        i_dat = 32'h31;
        step();
        i_vld = 1'b0;
        chk("ar_full", 64'(o_lvl), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(o_vld), 64'd0);
        chk("ar_rdy", 64'(i_rdy), 64'd1);
        chk("ar_lvl", 64'(o_lvl), 64'd0);
        chk("ar_dat", 64'(o_dat), 64'd0);
        #1 rst_n = 1'b1;
        o_rdy = 1'b1;
        repeat (3) step();
        chk("ar_after", 64'(o_lvl), 64'd0);

        // Random traffic
        base = acc_cnt;
        cyc = 0;
        while ((acc_cnt - base) < 10000 && cyc < 60000) begin
            step();
            i_vld = 1'($urandom_range(0, 1));
            o_rdy = 1'($urandom_range(0, 1));
            i_dat = $urandom;
            cyc++;
        end
        chk("rnd_budget", 64'(cyc < 60000), 64'd1);
        i_vld = 1'b0;
        o_rdy = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 10) begin
            step();
            cyc++;
        end
        step();
        chk("rnd_drain", 64'(o_lvl), 64'd0);
        chk("rnd_count", 64'(del_cnt + disc_cnt), 64'(acc_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
